ov7670_sccb_sender: RTL

Write-only SCCB master that consumes the 16-bit `{register address, value}` command stream from the OV7670 register table and drives it onto the camera's SIOC/SIOD pins. Each command is sent as one 3-phase write transaction. After each transaction the block pulses `advance` to request the next command, and it stops when the table raises `finished`. It sits between the register table and the camera's configuration pins, and it is clocked by the same system clock as the table.

---
 rtl/ov7670_sccb_sender.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ov7670_sccb_sender.sv
// Write-only SCCB master: streams {register address, value} commands from the
// OV7670 register table onto SIOC/SIOD as 3-phase write transactions.
module ov7670_sccb_sender #(
    parameter int         CLK_DIV    = 250,
    parameter logic [7:0] DEV_ADDR   = 8'h42,
    parameter int         INIT_WAIT  = 16,
    parameter int         GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        advance,
    output logic        sioc,
    output logic        siod,
    output logic        busy,
    output logic        done
);

    localparam int Q_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (INIT_WAIT > GAP_CYCLES) ? INIT_WAIT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [Q_W-1:0]   Q_LAST    = Q_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(INIT_WAIT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT,
        S_CHECK,
        S_START,
        S_BIT,
        S_STOP,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [Q_W-1:0]   q_cnt, q_cnt_n;
    logic [1:0]       phase, phase_n;
    logic [4:0]       bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [26:0]      sreg, sreg_n;
    logic             done_n, sioc_n, siod_n, busy_n, advance_n;
    logic             q_last;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_WAIT;
            q_cnt   <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
            sreg    <= '0;
            done    <= 1'b0;
            sioc    <= 1'b1;
            siod    <= 1'b1;
            busy    <= 1'b0;
            advance <= 1'b0;
        end else begin
            state   <= state_n;
            q_cnt   <= q_cnt_n;
            phase   <= phase_n;
            bit_cnt <= bit_cnt_n;
            cnt     <= cnt_n;
            sreg    <= sreg_n;
            done    <= done_n;
            sioc    <= sioc_n;
            siod    <= siod_n;
            busy    <= busy_n;
            advance <= advance_n;
        end
    end

    assign q_last = (q_cnt == Q_LAST);

    // NOTE: every variable assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_n   = state;
        q_cnt_n   = q_cnt;
        phase_n   = phase;
        bit_cnt_n = bit_cnt;
        cnt_n     = cnt;
        sreg_n    = sreg;
        done_n    = done;

        case (state)
            S_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_CHECK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (finished) begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end else begin
                    sreg_n    = {DEV_ADDR, 1'b1, command[15:8], 1'b1, command[7:0], 1'b1};
                    q_cnt_n   = '0;
                    phase_n   = '0;
                    bit_cnt_n = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (q_last) begin
                    q_cnt_n = '0;
                    if (phase == 2'd1) begin
                        phase_n = '0;
                        state_n = S_BIT;
                    end else begin
                        phase_n = phase + 2'd1;
                    end
                end else begin
                    q_cnt_n = q_cnt + 1'b1;
                end
            end
            S_BIT: begin
                if (q_last) begin
                    q_cnt_n = '0;
                    if (phase == 2'd3) begin
                        phase_n = '0;
                        sreg_n  = {sreg[25:0], 1'b0};
                        if (bit_cnt == 5'd26) begin
                            bit_cnt_n = '0;
                            state_n   = S_STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + 5'd1;
                        end
                    end else begin
                        phase_n = phase + 2'd1;
                    end
                end else begin
                    q_cnt_n = q_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (q_last) begin
                    q_cnt_n = '0;
                    if (phase == 2'd2) begin
                        phase_n = '0;
                        cnt_n   = '0;
                        state_n = S_GAP;
                    end else begin
                        phase_n = phase + 2'd1;
                    end
                end else begin
                    q_cnt_n = q_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = S_CHECK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE: ;
            default: state_n = S_WAIT;
        endcase
    end

    // Pin values are decoded from the next state and registered, so the pins
    // line up cycle-for-cycle with the state register and never see inputs.
    always_comb begin
        sioc_n    = 1'b1;
        siod_n    = 1'b1;
        busy_n    = 1'b0;
        advance_n = (state == S_STOP) && (state_n == S_GAP);

        case (state_n)
            S_START: begin
                busy_n = 1'b1;
                sioc_n = (phase_n == 2'd0);
                siod_n = 1'b0;
            end
            S_BIT: begin
                busy_n = 1'b1;
                sioc_n = phase_n[1];
                siod_n = sreg_n[26];
            end
            S_STOP: begin
                busy_n = 1'b1;
                sioc_n = (phase_n != 2'd0);
                siod_n = (phase_n == 2'd2);
            end
            default: ;
        endcase
    end

endmodule
